msu_audio_player: RTL and testbench
===================================

Name: msu_audio_player

Overview:
- Downstream of the MSU-1 audio sector fetcher.
- Accepts the 16-bit sector words streamed from the SD buffer and drops the 8-byte track header plus any words the fetcher flags as ignored. Stores the rest in a word FIFO and reports its fill level to the fetcher for back-pressure.
- Pops interleaved L/R pairs at 44.1 kHz, derived from a fractional clock accumulator, and presents registered stereo samples to the audio mixer.

Parameters:
- CLK_HZ, 21477270, clk frequency in Hz.
- SAMPLE_HZ, 44100, output sample rate in Hz; must be < CLK_HZ/8.
- DEPTH_LOG2, 11, FIFO depth = 2**DEPTH_LOG2 16-bit words.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  one-cycle pulse on new track trigger; empties FIFO.
- wr_en  in  1  SD buffer word strobe (sd_ack & sd_buff_wr).
- wr_data  in  16  SD buffer word, little-endian signed PCM.
- ignore  in  1  drop this word (loop-offset skip from fetcher).
- hdr_sector  in  1  high while the transferred sector is LBA 0.
- word_index  in  9  index of the current word within the sector.
- play  in  1  playback enable.
- volume  in  8  MSU volume register.
- usedw  out  DEPTH_LOG2+1  FIFO words held, 0..2**DEPTH_LOG2.
- sample_strobe  out  1  one-cycle pulse when left_out/right_out update.
- left_out  out  16  signed left sample.
- right_out  out  16  signed right sample.
- underrun_cnt  out  16  saturating count of starved sample periods.
- overflow  out  1  sticky; set when a word is dropped on full.

Behaviour:
- Reset (or flush): pointers, usedw, left_out, right_out, sample_strobe all 0; read FSM to IDLE.
  - Reset only: also clears the rate accumulator, underrun_cnt and overflow.
  - flush has priority over a same-cycle write.
- Write acceptance: word stored iff wr_en & !ignore & !(hdr_sector & word_index<4) & !full. ignore is sampled in the same cycle as wr_en.
- Full write: the word is discarded, overflow <= 1, usedw unchanged.
- usedw: +1 per accepted write, -1 per pop, net 0 on a same-cycle write and pop. Registered; reflects a cycle-T event at T+1.
- Rate generator: 25-bit acc.
  - Each cycle: n = acc + SAMPLE_HZ.
  - If n >= CLK_HZ: acc <= n - CLK_HZ and tick = 1; else acc <= n.
  - Long-run tick rate equals SAMPLE_HZ exactly.
- Read FSM, with synchronous-read RAM of 1-cycle latency:
  - IDLE: on tick, branch on play and usedw:
    - play & usedw >= 2: issue read at rp, go FETCH_L.
    - play & usedw < 2: outputs <= 0, sample_strobe pulse, underrun_cnt += 1 (saturating at 0xFFFF), stay IDLE.
    - !play: outputs <= 0, sample_strobe pulse, no pop, no count.
  - FETCH_L: capture left, issue read rp+1, go FETCH_R.
  - FETCH_R: capture right, rp += 2, usedw -= 2, go SCALE.
  - SCALE: drive left_out/right_out (volume path), sample_strobe = 1, go IDLE.
  - Latency: tick at T -> sample_strobe and outputs at T+3.
  - A tick while not in IDLE is ignored (cannot occur under the SAMPLE_HZ constraint).
- Pointers wrap modulo 2**DEPTH_LOG2. Full = usedw == 2**DEPTH_LOG2. An odd leftover word stays until the next write or flush.
- Outputs hold their values between strobes.

Optional Feature:
- Macro MSU_VOLUME_EN.
- Defined: each channel out = (sample * {1'b0,volume}) >>> 8, a signed 16x9 multiply to a 25-bit product, taking bits [23:8] with floor rounding. volume=255 gives approximately 0.996x; volume=0 gives 0.
- Undefined: the volume input is ignored and samples pass through unchanged in SCALE.

Test Plan:
- Reset asserted 3 cycles mid-playback -> usedw=0, left_out=right_out=0, overflow=0, underrun_cnt=0, next strobe outputs 0.
- hdr_sector=1, 10 writes of 0x1000+i with word_index=i, play=1, no macro -> usedw=6; first sample_strobe L=0x1004 R=0x1005; usedw=4 afterwards.
- 6 writes with ignore=1 on the 2nd..4th -> usedw=3; only words 1, 5, 6 reach the output, in order.
- 2049 writes with no reads, DEPTH_LOG2=11 -> usedw=2048, overflow=1; words 1..2048 read back intact.
- CLK_HZ=441000, SAMPLE_HZ=44100, play=1, FIFO empty -> sample_strobe exactly every 10 cycles, outputs 0, underrun_cnt increments 1 per strobe; flush with a same-cycle write -> usedw=0.
- MSU_VOLUME_EN, volume=0x80, pair 0x4000/0xC000 -> left_out=0x2000, right_out=0xE000; volume=0 -> 0x0000/0x0000.

Source files
------------

// File: rtl/msu_audio_player.sv
// MSU-1 audio player: header/ignore filtering, word FIFO and 44.1 kHz stereo sample pop.
// Optional `MSU_VOLUME_EN scales both channels by the MSU volume register.
module msu_audio_player #(
    parameter int CLK_HZ     = 21477270,
    parameter int SAMPLE_HZ  = 44100,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [15:0]           wr_data,
    input  logic                  ignore,
    input  logic                  hdr_sector,
    input  logic [8:0]            word_index,
    input  logic                  play,
    input  logic [7:0]            volume,
    output logic [DEPTH_LOG2:0]   usedw,
    output logic                  sample_strobe,
    output logic [15:0]           left_out,
    output logic [15:0]           right_out,
    output logic [15:0]           underrun_cnt,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] TWO      = (DEPTH_LOG2+1)'(2);

    typedef enum logic [1:0] {IDLE, FETCH_L, FETCH_R, SCALE} state_t;
    state_t state, state_next;

    logic [15:0]           mem [DEPTH];
    logic [15:0]           rd_data;
    logic [15:0]           left_sample;
    logic [DEPTH_LOG2-1:0] wp, rp, rd_addr;
    logic [24:0]           acc;
    logic [25:0]           acc_sum;
    logic                  tick, storable, full, wr_accept;
    logic                  rd_en, load_l, load_out, pop, idle_strobe, underrun;
    logic [15:0]           scaled_l, scaled_r;

    assign acc_sum   = {1'b0, acc} + 26'(SAMPLE_HZ);
    assign tick      = acc_sum >= 26'(CLK_HZ);
    assign full      = usedw == FULL_LVL;
    // The first four words of LBA 0 are the "MSU1" tag and loop offset, not audio.
    assign storable  = wr_en & ~ignore & ~(hdr_sector & (word_index < 9'd4));
    assign wr_accept = storable & ~full;

`ifdef MSU_VOLUME_EN
    logic signed [24:0] prod_l, prod_r;
    assign prod_l   = $signed(left_sample) * $signed({1'b0, volume});
    assign prod_r   = $signed(rd_data) * $signed({1'b0, volume});
    assign scaled_l = 16'(prod_l >>> 8);
    assign scaled_r = 16'(prod_r >>> 8);
`else
    logic unused_volume;
    assign unused_volume = ^volume;
    assign scaled_l      = left_sample;
    assign scaled_r      = rd_data;
`endif

    always_comb begin
        state_next  = state;
        rd_en       = 1'b0;
        rd_addr     = rp;
        load_l      = 1'b0;
        load_out    = 1'b0;
        pop         = 1'b0;
        idle_strobe = 1'b0;
        underrun    = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    if (play && usedw >= TWO) begin
                        rd_en      = 1'b1;
                        state_next = FETCH_L;
                    end else begin
                        idle_strobe = 1'b1;
                        underrun    = play;
                    end
                end
            end
            FETCH_L: begin
                load_l     = 1'b1;
                rd_en      = 1'b1;
                rd_addr    = rp + 1'b1;
                state_next = FETCH_R;
            end
            // Outputs register here so they are visible while the FSM sits in SCALE.
            FETCH_R: begin
                load_out   = 1'b1;
                pop        = 1'b1;
                state_next = SCALE;
            end
            SCALE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) state <= IDLE;
        else                state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !flush) mem[wp] <= wr_data;
        if (rd_en)               rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp            <= '0;
            rp            <= '0;
            usedw         <= '0;
            left_sample   <= '0;
            left_out      <= '0;
            right_out     <= '0;
            sample_strobe <= 1'b0;
        end else begin
            if (wr_accept) wp <= wp + 1'b1;
            if (pop)       rp <= rp + 2'd2;
            usedw         <= usedw + (DEPTH_LOG2+1)'(wr_accept) - (pop ? TWO : '0);
            sample_strobe <= idle_strobe | load_out;
            if (load_l) left_sample <= rd_data;
            if (idle_strobe) begin
                left_out  <= '0;
                right_out <= '0;
            end else if (load_out) begin
                left_out  <= scaled_l;
                right_out <= scaled_r;
            end
        end
    end

    // Rate accumulator and error counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            underrun_cnt <= '0;
            overflow     <= 1'b0;
        end else begin
            acc <= tick ? 25'(acc_sum - 26'(CLK_HZ)) : 25'(acc_sum);
            if (!flush && underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            if (!flush && storable && full) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_msu_audio_player.sv
// Directed bench for msu_audio_player: expected stereo pairs queued by the driver,
// compared by a monitor on every sample_strobe while monitoring is enabled.
module tb_msu_audio_player;
    localparam int DL = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1, flush = 1'b0, wr_en = 1'b0, ignore = 1'b0;
    logic          hdr_sector = 1'b0, play = 1'b0;
    logic [15:0]   wr_data = '0;
    logic [8:0]    word_index = '0;
    logic [7:0]    volume = 8'hFF;
    logic [DL:0]   usedw;
    logic          sample_strobe, overflow;
    logic [15:0]   left_out, right_out, underrun_cnt;

    int            checks = 0, errors = 0, cyc = 0;
    logic          mon_en = 1'b0;
    logic [31:0]   exp_q[$];

    msu_audio_player #(.CLK_HZ(441000), .SAMPLE_HZ(44100), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .ignore(ignore), .hdr_sector(hdr_sector), .word_index(word_index), .play(play),
        .volume(volume), .usedw(usedw), .sample_strobe(sample_strobe), .left_out(left_out),
        .right_out(right_out), .underrun_cnt(underrun_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] s);
`ifdef MSU_VOLUME_EN
        logic signed [24:0] p;
        p = $signed(s) * $signed({1'b0, volume});
        return p[23:8];
`else
        return s;
`endif
    endfunction

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        exp_q.push_back({model(l), model(r)});
    endtask

    // Monitor: one comparison per strobe.
    always @(negedge clk) begin
        if (mon_en && sample_strobe) begin
            logic [31:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %0h expected none", {left_out, right_out});
            end else begin
                e = exp_q.pop_front();
                check("sample_pair", {left_out, right_out}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] d, input logic ign, input logic hdr, input logic [8:0] idx);
        wr_en = 1'b1; wr_data = d; ignore = ign; hdr_sector = hdr; word_index = idx;
        step();
        wr_en = 1'b0; ignore = 1'b0; hdr_sector = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        @(negedge clk);
        while (!sample_strobe && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!sample_strobe) begin
            checks++;
            errors++;
            $display("FAIL %s: got no strobe expected strobe within 100 cycles", name);
        end
    endtask

    // Align to an idle strobe so enabling the monitor cannot catch a stale !play strobe.
    task automatic start_play();
        wait_strobe("idle_strobe");
        step();
        mon_en = 1'b1;
        play   = 1'b1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic stop_play();
        play   = 1'b0;
        mon_en = 1'b0;
    endtask

    initial begin
        int t_prev;
        t_prev = 0;
        // Power-on reset with play already high.
        play = 1'b1;
        repeat (3) step();
        check("rst_usedw", 32'(usedw), 0);
        check("rst_left", 32'(left_out), 0);
        check("rst_right", 32'(right_out), 0);
        check("rst_strobe", 32'(sample_strobe), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_underrun", 32'(underrun_cnt), 0);
        reset = 1'b0;

        // Empty FIFO with play: zero samples every 10 cycles, underrun counting.
        repeat (5) exp_q.push_back(32'h0);
        mon_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_strobe("underrun_strobe");
            if (k > 1) check("strobe_period", 32'(cyc - t_prev), 10);
            check("underrun_cnt", 32'(underrun_cnt), 32'(k));
            t_prev = cyc;
        end
        step();
        stop_play();
        drain(5);

        // Flush wins over a same-cycle write.
        for (int i = 0; i < 3; i++) write_word(16'h0A00 + 16'(i), 1'b0, 1'b0, 9'd0);
        check("pre_flush_usedw", 32'(usedw), 3);
        flush = 1'b1; wr_en = 1'b1; wr_data = 16'h0BAD;
        step();
        flush = 1'b0; wr_en = 1'b0;
        check("flush_usedw", 32'(usedw), 0);

        // Header sector: words 0..3 dropped.
        for (int i = 0; i < 10; i++) write_word(16'h1000 + 16'(i), 1'b0, 1'b1, 9'(i));
        check("hdr_usedw", 32'(usedw), 6);
        push_pair(16'h1004, 16'h1005);
        push_pair(16'h1006, 16'h1007);
        push_pair(16'h1008, 16'h1009);
        start_play();
        wait_strobe("hdr_first_strobe");
        check("hdr_usedw_after", 32'(usedw), 4);
        drain(100);
        stop_play();

        // Ignored words never reach the FIFO; odd leftover waits for its partner.
        write_word(16'h2001, 1'b0, 1'b0, 9'd0);
        write_word(16'h2002, 1'b1, 1'b0, 9'd0);
        write_word(16'h2003, 1'b1, 1'b0, 9'd0);
        write_word(16'h2004, 1'b1, 1'b0, 9'd0);
        write_word(16'h2005, 1'b0, 1'b0, 9'd0);
        write_word(16'h2006, 1'b0, 1'b0, 9'd0);
        check("ign_usedw", 32'(usedw), 3);
        push_pair(16'h2001, 16'h2005);
        start_play();
        drain(100);
        stop_play();
        check("ign_leftover", 32'(usedw), 1);
        write_word(16'h2007, 1'b0, 1'b0, 9'd0);
        push_pair(16'h2006, 16'h2007);
        start_play();
        drain(100);
        stop_play();
        check("ign_usedw_end", 32'(usedw), 0);

        // Overfill: 2049 writes, last one dropped.
        for (int i = 1; i <= 2049; i++) write_word(16'(i), 1'b0, 1'b0, 9'd0);
        check("full_usedw", 32'(usedw), 2048);
        check("full_overflow", 32'(overflow), 1);
        for (int i = 0; i < 1024; i++) push_pair(16'(2 * i + 1), 16'(2 * i + 2));
        start_play();
        drain(11000);
        stop_play();
        check("full_drained", 32'(usedw), 0);

        // Reset in the middle of playback.
        for (int i = 1; i <= 4; i++) write_word(16'h3000 + 16'(i), 1'b0, 1'b0, 9'd0);
        push_pair(16'h3001, 16'h3002);
        start_play();
        drain(100);
        mon_en = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check("mid_rst_usedw", 32'(usedw), 0);
        check("mid_rst_left", 32'(left_out), 0);
        check("mid_rst_right", 32'(right_out), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        check("mid_rst_underrun", 32'(underrun_cnt), 0);
        exp_q.push_back(32'h0);
        mon_en = 1'b1;
        drain(30);
        check("post_rst_underrun", 32'(underrun_cnt), 1);
        stop_play();

`ifdef MSU_VOLUME_EN
        volume = 8'h80;
        write_word(16'h4000, 1'b0, 1'b0, 9'd0);
        write_word(16'hC000, 1'b0, 1'b0, 9'd0);
        exp_q.push_back({16'h2000, 16'hE000});
        start_play();
        drain(100);
        stop_play();
        volume = 8'h00;
        write_word(16'h1234, 1'b0, 1'b0, 9'd0);
        write_word(16'h8765, 1'b0, 1'b0, 9'd0);
        exp_q.push_back(32'h0);
        start_play();
        drain(100);
        stop_play();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
